// File: rtl/act_unit_mc.sv
// act_unit_mc: two-stage multi-channel activation (rescale + saturate, then ReLU / leaky / clipped / identity).
// Build option: define ACT_ROUND_EN for round-half-up on the rescale shifts (default truncates toward -inf).
module act_unit_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int INT_WIDTH  = 4,
  parameter int NUM_CH     = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-1:0]          clip_val,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]              out_sat,
  input  logic                           sat_clr,
  output logic [CNT_WIDTH-1:0]           sat_count
);

  localparam int W  = DATA_WIDTH;
  localparam int F  = DATA_WIDTH - INT_WIDTH;
  localparam int XW = 2 * DATA_WIDTH;
  localparam int IW = 2 * DATA_WIDTH + 1;
  localparam int LF = F + LEAK_SHIFT;

  localparam logic [1:0] MODE_RELU  = 2'b00;
  localparam logic [1:0] MODE_LEAKY = 2'b01;
  localparam logic [1:0] MODE_CLIP  = 2'b10;

  localparam logic signed [IW-1:0] SAT_MAX = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         W_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         W_MIN   = {1'b1, {(W-1){1'b0}}};

`ifdef ACT_ROUND_EN
  localparam logic signed [IW-1:0] RND_BASE = IW'(1) << (F - 1);
  localparam logic signed [IW-1:0] RND_LEAK = IW'(1) << (LF - 1);
`endif

  logic en;
  logic in_fire;

  logic                       s1_valid_d, s1_valid_q;
  logic [NUM_CH-1:0][W-1:0]   s1_val_d, s1_val_q;
  logic [NUM_CH-1:0]          s1_ovf_d, s1_ovf_q;
  logic [NUM_CH-1:0]          s1_pos_d, s1_pos_q;
  logic [1:0]                 s1_mode_d, s1_mode_q;
  logic [W-1:0]               s1_clip_d, s1_clip_q;

  logic [NUM_CH-1:0][W-1:0]   s2_val;
  logic [NUM_CH-1:0]          s2_sat;

  logic                       out_valid_d, out_valid_q;
  logic [NUM_CH-1:0][W-1:0]   out_data_d, out_data_q;
  logic [NUM_CH-1:0]          out_sat_d, out_sat_q;
  logic [CNT_WIDTH-1:0]       sat_cnt_d, sat_cnt_q;
  logic [CNT_WIDTH:0]         sat_pop;
  logic [CNT_WIDTH:0]         sat_sum;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && rst_n;
  assign in_fire  = in_valid && in_ready;

  // Stage 1: rescale each channel (leaky negatives use the longer shift) and saturate.
  always_comb begin : stage1_comb
    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] x_adj;
    logic signed [IW-1:0] scaled;
    logic                 leak_neg;
    s1_valid_d = s1_valid_q;
    s1_val_d   = s1_val_q;
    s1_ovf_d   = s1_ovf_q;
    s1_pos_d   = s1_pos_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    x_ext      = '0;
    x_adj      = '0;
    scaled     = '0;
    leak_neg   = 1'b0;
    if (en) begin
      s1_valid_d = in_fire;
    end
    if (in_fire) begin
      s1_mode_d = mode;
      s1_clip_d = clip_val;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        x_ext    = {in_data[c*XW + XW - 1], in_data[c*XW +: XW]};
        leak_neg = (mode == MODE_LEAKY) && x_ext[IW-1];
`ifdef ACT_ROUND_EN
        x_adj    = x_ext + (leak_neg ? RND_LEAK : RND_BASE);
`else
        x_adj    = x_ext;
`endif
        scaled   = leak_neg ? (x_adj >>> LF) : (x_adj >>> F);
        if (scaled > SAT_MAX) begin
          s1_val_d[c] = W_MAX;
          s1_ovf_d[c] = 1'b1;
        end else if (scaled < SAT_MIN) begin
          s1_val_d[c] = W_MIN;
          s1_ovf_d[c] = 1'b1;
        end else begin
          s1_val_d[c] = scaled[W-1:0];
          s1_ovf_d[c] = 1'b0;
        end
        s1_pos_d[c] = !x_ext[IW-1] && (x_ext != '0);
      end
    end
  end

  // Stage 2: mode selection; the clip ceiling is compared unsigned against a non-negative value.
  always_comb begin : stage2_comb
    s2_val = '0;
    s2_sat = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case (s1_mode_q)
        MODE_RELU, MODE_CLIP: begin
          if (s1_pos_q[c]) begin
            s2_val[c] = s1_val_q[c];
            s2_sat[c] = s1_ovf_q[c];
          end
          if ((s1_mode_q == MODE_CLIP) && (s2_val[c] > s1_clip_q)) begin
            s2_val[c] = s1_clip_q;
          end
        end
        default: begin
          s2_val[c] = s1_val_q[c];
          s2_sat[c] = s1_ovf_q[c];
        end
      endcase
    end
  end

  always_comb begin : out_comb
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;
    sat_pop     = '0;
    sat_sum     = '0;
    if (en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s2_val;
        out_sat_d  = s2_sat;
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sat_pop = sat_pop + {{CNT_WIDTH{1'b0}}, s2_sat[c]};
    end
    sat_sum = {1'b0, sat_cnt_q} + sat_pop;
    // Clear takes priority over a simultaneous load; that load's events are dropped.
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (en && s1_valid_q) begin
      sat_cnt_d = sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_ovf_q    <= '0;
      s1_pos_q    <= '0;
      s1_mode_q   <= '0;
      s1_clip_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_ovf_q    <= s1_ovf_d;
      s1_pos_q    <= s1_pos_d;
      s1_mode_q   <= s1_mode_d;
      s1_clip_q   <= s1_clip_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_act_unit_mc.sv
// tb_act_unit_mc: randomized and directed checks of act_unit_mc against an arithmetic reference model.
// Honours ACT_ROUND_EN the same way as the design.
module tb_act_unit_mc;

  localparam int W   = 16;
  localparam int I   = 4;
  localparam int F   = W - I;
  localparam int NCH = 4;
  localparam int LS  = 3;
  localparam int CW  = 16;

`ifdef ACT_ROUND_EN
  localparam logic [W-1:0] RND_EXP = 16'h0001;
`else
  localparam logic [W-1:0] RND_EXP = 16'h0000;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [NCH*2*W-1:0]     in_data = '0;
  logic [1:0]             mode = 2'b00;
  logic [W-1:0]           clip_val = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [NCH*W-1:0]       out_data;
  logic [NCH-1:0]         out_sat;
  logic                   sat_clr = 1'b0;
  logic [CW-1:0]          sat_count;

  always #5 clk = ~clk;

  act_unit_mc #(
    .DATA_WIDTH(W),
    .INT_WIDTH (I),
    .NUM_CH    (NCH),
    .LEAK_SHIFT(LS),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mode     (mode),
    .clip_val (clip_val),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_cnt  = 0;
  int     stall_err;

  logic [NCH*2*W-1:0] tx_data[$];
  logic [1:0]         tx_mode[$];
  logic [W-1:0]       tx_clip[$];
  logic [NCH*W-1:0]   rx_data[$];
  logic [NCH-1:0]     rx_sat[$];

  // Reference: floor-shift (optionally half-up biased), clamp, then the activation rule.
  function automatic void ref_ch(input logic [2*W-1:0] xr, input logic [1:0] m,
                                 input logic [W-1:0] clip, output logic [W-1:0] y,
                                 output logic s);
    longint x, v, k, hi, lo, cl;
    x  = longint'($signed(xr));
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    cl = clip;
    k  = (m == 2'd1 && x < 0) ? F + LS : F;
    v  = x;
`ifdef ACT_ROUND_EN
    v  = v + (64'sd1 <<< (k - 1));
`endif
    v  = v >>> k;
    s  = 1'b0;
    if (v > hi) begin v = hi; s = 1'b1; end
    else if (v < lo) begin v = lo; s = 1'b1; end
    if (m == 2'd0 || m == 2'd2) begin
      if (x <= 0) begin v = 0; s = 1'b0; end
      if (m == 2'd2 && v > cl) v = cl;
    end
    y = v[W-1:0];
  endfunction

  function automatic void ref_beat(input logic [NCH*2*W-1:0] d, input logic [1:0] m,
                                   input logic [W-1:0] clip, output logic [NCH*W-1:0] y,
                                   output logic [NCH-1:0] s);
    logic [W-1:0] yc;
    logic         sc;
    y = '0;
    s = '0;
    for (int c = 0; c < NCH; c++) begin
      ref_ch(d[c*2*W +: 2*W], m, clip, yc, sc);
      y[c*W +: W] = yc;
      s[c]        = sc;
    end
  endfunction

  function automatic void add_cnt(input logic [NCH-1:0] s);
    exp_cnt = exp_cnt + $countones(s);
    if (exp_cnt > 65535) exp_cnt = 65535;
  endfunction

  // Present one beat with out_ready high; lat counts cycles until out_valid (2 = two register stages).
  task automatic one_beat(input logic [NCH*2*W-1:0] d, input logic [1:0] m, input logic [W-1:0] cv,
                          output logic [NCH*W-1:0] od, output logic [NCH-1:0] os, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    clip_val  = cv;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    od = out_data;
    os = out_sat;
  endtask

  // Streams tx_* into the DUT; pat 0 = ready always, 1 = ready 1,0,0,1 repeating, 2 = random.
  task automatic stream(input int pat, input int max_cycles, output bit timed_out);
    int               idx, got, cyc, total;
    bit               prev_stall;
    logic [NCH*W-1:0] prev_d;
    logic [NCH-1:0]   prev_s;
    idx = 0; got = 0; cyc = 0; total = tx_data.size();
    prev_stall = 1'b0; prev_d = '0; prev_s = '0;
    stall_err = 0;
    rx_data.delete();
    rx_sat.delete();
    while (got < total && cyc < max_cycles) begin
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_d || out_sat !== prev_s)) stall_err++;
      case (pat)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (idx < total) begin
        in_valid = 1'b1;
        in_data  = tx_data[idx];
        mode     = tx_mode[idx];
        clip_val = tx_clip[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_sat.push_back(out_sat);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_s     = out_sat;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    timed_out = (got < total);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (out_sat !== '0) begin n_fail++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
    n_checks++; if (sat_count !== '0) begin n_fail++; $display("FAIL reset_sat_count: got %h expected 0", sat_count); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_relu();
    logic [NCH*W-1:0] od;
    logic [NCH-1:0]   os;
    int               lat;
    one_beat({32'h0000_0000, 32'h1000_0000, 32'hFF00_0000, 32'h0180_0000}, 2'b00, 16'h0000, od, os, lat);
    exp_cnt = exp_cnt + 1;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL relu_latency: got %0d expected 2", lat); end
    n_checks++; if (od[15:0] !== 16'h1800) begin n_fail++; $display("FAIL relu_ch0: got %h expected 1800", od[15:0]); end
    n_checks++; if (od[31:16] !== 16'h0000) begin n_fail++; $display("FAIL relu_ch1: got %h expected 0000", od[31:16]); end
    n_checks++; if (od[47:32] !== 16'h7FFF) begin n_fail++; $display("FAIL relu_ch2: got %h expected 7fff", od[47:32]); end
    n_checks++; if (od[63:48] !== 16'h0000) begin n_fail++; $display("FAIL relu_ch3: got %h expected 0000", od[63:48]); end
    n_checks++; if (os !== 4'b0100) begin n_fail++; $display("FAIL relu_sat: got %b expected 0100", os); end
    n_checks++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL relu_count: got %0d expected 1", sat_count); end
  endtask

  task automatic test_leaky_identity();
    logic [NCH*W-1:0] od, ed;
    logic [NCH-1:0]   os, es;
    logic [NCH*2*W-1:0] d;
    int               lat;
    d = {96'h0, 32'hFF00_0000};
    one_beat(d, 2'b01, 16'h0000, od, os, lat);
    ref_beat(d, 2'b01, 16'h0000, ed, es); add_cnt(es);
    n_checks++; if (od[15:0] !== 16'hFE00) begin n_fail++; $display("FAIL leaky_neg: got %h expected fe00", od[15:0]); end
    d = {32'h0, 32'hFF00_0000, 32'h8000_0000, 32'h0};
    one_beat(d, 2'b11, 16'h0000, od, os, lat);
    ref_beat(d, 2'b11, 16'h0000, ed, es); add_cnt(es);
    n_checks++; if (od[31:16] !== 16'h8000) begin n_fail++; $display("FAIL ident_min: got %h expected 8000", od[31:16]); end
    n_checks++; if (os[1] !== 1'b1) begin n_fail++; $display("FAIL ident_min_sat: got %b expected 1", os[1]); end
    n_checks++; if (od[47:32] !== 16'hF000) begin n_fail++; $display("FAIL ident_neg: got %h expected f000", od[47:32]); end
    n_checks++; if (sat_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ident_count: got %0d expected %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_clipped();
    logic [NCH*W-1:0] od, ed;
    logic [NCH-1:0]   os, es;
    logic [NCH*2*W-1:0] d;
    int               lat;
    d = {64'h0, 32'h0200_0000, 32'h0700_0000};
    one_beat(d, 2'b10, 16'h6000, od, os, lat);
    ref_beat(d, 2'b10, 16'h6000, ed, es); add_cnt(es);
    n_checks++; if (od[15:0] !== 16'h6000) begin n_fail++; $display("FAIL clip_ceiling: got %h expected 6000", od[15:0]); end
    n_checks++; if (os[0] !== 1'b0) begin n_fail++; $display("FAIL clip_no_sat: got %b expected 0", os[0]); end
    n_checks++; if (od[31:16] !== 16'h2000) begin n_fail++; $display("FAIL clip_pass: got %h expected 2000", od[31:16]); end
  endtask

  task automatic test_rounding();
    logic [NCH*W-1:0] od, ed;
    logic [NCH-1:0]   os, es;
    logic [NCH*2*W-1:0] d;
    int               lat;
    d = {96'h0, 32'h0000_0800};
    one_beat(d, 2'b11, 16'h0000, od, os, lat);
    ref_beat(d, 2'b11, 16'h0000, ed, es); add_cnt(es);
    n_checks++; if (od[15:0] !== RND_EXP) begin n_fail++; $display("FAIL round_half: got %h expected %h", od[15:0], RND_EXP); end
  endtask

  task automatic test_backpressure();
    logic [NCH*2*W-1:0] d;
    logic [NCH*W-1:0]   ed;
    logic [NCH-1:0]     es;
    logic [31:0]        v;
    bit                 to;
    int                 n;
    tx_data.delete(); tx_mode.delete(); tx_clip.delete();
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NCH; c++) begin
        v = 32'h0010_0000 * (i + 1) + 32'h0003_0000 * c;
        d[c*2*W +: 2*W] = (c % 2 == 1) ? -v : v;
      end
      tx_data.push_back(d);
      tx_mode.push_back(2'(i % 4));
      tx_clip.push_back(16'h0400);
    end
    stream(1, 200, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", to); end
    n_checks++; if (rx_data.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", rx_data.size()); end
    n = (rx_data.size() < 8) ? rx_data.size() : 8;
    for (int i = 0; i < n; i++) begin
      ref_beat(tx_data[i], tx_mode[i], tx_clip[i], ed, es); add_cnt(es);
      n_checks++;
      if (rx_data[i] !== ed || rx_sat[i] !== es) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, rx_data[i], rx_sat[i], ed, es);
      end
    end
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
    n_checks++; if (sat_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_sat_count: got %0d expected %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_random();
    logic [NCH*2*W-1:0] d;
    logic [NCH*W-1:0]   ed;
    logic [NCH-1:0]     es;
    logic signed [31:0] t;
    bit                 to;
    int                 bad, n;
    tx_data.delete(); tx_mode.delete(); tx_clip.delete();
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NCH; c++) begin
        t = $signed($urandom);
        t = t >>> $urandom_range(0, 20);
        if ($urandom_range(0, 15) == 0) t = 0;
        d[c*2*W +: 2*W] = t;
      end
      tx_data.push_back(d);
      tx_mode.push_back(2'($urandom_range(0, 3)));
      tx_clip.push_back(16'($urandom));
    end
    stream(2, 3000, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %b expected 0", to); end
    n_checks++; if (rx_data.size() !== 300) begin n_fail++; $display("FAIL rand_count: got %0d expected 300", rx_data.size()); end
    n = (rx_data.size() < 300) ? rx_data.size() : 300;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      ref_beat(tx_data[i], tx_mode[i], tx_clip[i], ed, es); add_cnt(es);
      n_checks++;
      if (rx_data[i] !== ed || rx_sat[i] !== es) begin
        n_fail++; bad++;
        if (bad <= 5) $display("FAIL rand_beat%0d mode %0d: got %h/%b expected %h/%b", i, tx_mode[i], rx_data[i], rx_sat[i], ed, es);
      end
    end
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stall_err); end
    n_checks++; if (sat_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand_sat_count: got %0d expected %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_sat_clr();
    @(negedge clk);
    n_checks++; if (sat_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL clr_pre_count: got %0d expected %0d", sat_count, exp_cnt); end
    in_valid  = 1'b1;
    in_data   = {4{32'h7FFF_0000}};
    mode      = 2'b11;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    exp_cnt = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sat !== 4'hF) begin n_fail++; $display("FAIL clr_out_sat: got %b expected 1111", out_sat); end
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d expected 0", sat_count); end
  endtask

  task automatic test_counter_saturation();
    logic [NCH*W-1:0] ed;
    logic [NCH-1:0]   es;
    bit               to;
    int               bad, n;
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    exp_cnt = 0;
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL cnt_cleared: got %0d expected 0", sat_count); end
    tx_data.delete(); tx_mode.delete(); tx_clip.delete();
    for (int i = 0; i < 20000; i++) begin
      tx_data.push_back((i % 2 == 0) ? {4{32'h7FFF_0000}} : {4{32'h8000_0000}});
      tx_mode.push_back(2'b11);
      tx_clip.push_back(16'h0000);
    end
    stream(0, 25000, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL cnt_timeout: got %b expected 0", to); end
    n = rx_data.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      ref_beat(tx_data[i], tx_mode[i], tx_clip[i], ed, es); add_cnt(es);
      if (rx_data[i] !== ed || rx_sat[i] !== es) bad++;
    end
    n_checks++; if (bad !== 0 || n !== 20000) begin n_fail++; $display("FAIL cnt_beats: got %0d bad of %0d expected 0 bad of 20000", bad, n); end
    n_checks++; if (sat_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sticky_max: got %h expected ffff", sat_count); end
  endtask

  task automatic test_reset_in_flight();
    int seen;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {4{32'h7FFF_0000}};
    mode      = 2'b11;
    @(negedge clk);
    in_data = {4{32'h8000_0000}};
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rif_stalled_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL rif_sat_count: got %h expected 0", sat_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rif_in_ready: got %b expected 0", in_ready); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rif_no_ghost: got %0d beats expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky_identity();
    test_clipped();
    test_rounding();
    test_backpressure();
    test_random();
    test_sat_clr();
    test_counter_saturation();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
